// File: rtl/regfile_pkg.sv
// Shared defaults and port-slice helper for the multi-port register file.
// Imported by regfile_mp and regfile_scoreboard.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREG  = 16;
  localparam int DEF_AW    = 4;
  localparam int DEF_NRD   = 3;
  localparam int DEF_NWR   = 2;

  // Highest index aliases the externally sourced PC.
  localparam int PC_IDX = DEF_NREG - 1;

  // Port p of a flattened bus lives at [slice_lo(p, w) +: w].
  function automatic int slice_lo(input int port, input int w);
    return port * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write busy bits: set by issue, cleared by writeback (set wins).
// Ports: clk, reset_n, iss_v/iss_a, we/wa/wb_clr, ra in; rd_busy out.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW,
  parameter int NRD  = DEF_NRD,
  parameter int NWR  = DEF_NWR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              iss_v,
  input  logic [AW-1:0]     iss_a,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic [NWR-1:0]    wb_clr,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREG-2:0] busy_q;
  logic [NREG-2:0] busy_d;
  logic [NREG-2:0] clr;

  always_comb begin
    clr = '0;
    for (int r = 0; r < NREG - 1; r++) begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && wb_clr[j] &&
            wa[slice_lo(j, AW) +: AW] == AW'(r))
          clr[r] = 1'b1;
      end
    end
  end

  // A new producer supersedes a retiring one.
  always_comb begin
    busy_d = busy_q & ~clr;
    for (int r = 0; r < NREG - 1; r++) begin
      if (iss_v && iss_a == AW'(r))
        busy_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  // Results arriving this cycle are bypassed, so they do not stall.
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      for (int r = 0; r < NREG - 1; r++) begin
        if (ra[slice_lo(i, AW) +: AW] == AW'(r))
          rd_busy[i] = busy_q[r] & ~clr[r];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-through bypass and busy scoreboard.
// Ports: clk, reset_n, ra/rd/rd_busy reads, we/wa/wd/wb_clr writes, pc_val, iss_v/iss_a.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int AW    = DEF_AW,
  parameter int NRD   = DEF_NRD,
  parameter int NWR   = DEF_NWR
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    wa,
  input  logic [NWR*WIDTH-1:0] wd,
  input  logic [WIDTH-1:0]     pc_val,
  input  logic                 iss_v,
  input  logic [AW-1:0]        iss_a,
  input  logic [NWR-1:0]       wb_clr
);

  localparam logic [AW-1:0] PC_A = AW'(NREG - 1);

  logic [WIDTH-1:0] regs_q [NREG-1];
  logic [WIDTH-1:0] regs_d [NREG-1];

  // Ascending port scan: the highest-index port wins a collision.
  // The PC index has no storage, so writes to it fall through.
  always_comb begin
    regs_d = regs_q;
    for (int r = 0; r < NREG - 1; r++) begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && wa[slice_lo(j, AW) +: AW] == AW'(r))
          regs_d[r] = wd[slice_lo(j, WIDTH) +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG - 1; r++)
        regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Same priority as the write path, so bypass matches storage.
  always_comb begin
    rd = '0;
    for (int i = 0; i < NRD; i++) begin
      if (ra[slice_lo(i, AW) +: AW] == PC_A) begin
        rd[slice_lo(i, WIDTH) +: WIDTH] = pc_val;
      end else begin
        for (int r = 0; r < NREG - 1; r++) begin
          if (ra[slice_lo(i, AW) +: AW] == AW'(r))
            rd[slice_lo(i, WIDTH) +: WIDTH] = regs_q[r];
        end
        for (int j = 0; j < NWR; j++) begin
          if (we[j] &&
              wa[slice_lo(j, AW) +: AW] == ra[slice_lo(i, AW) +: AW])
            rd[slice_lo(i, WIDTH) +: WIDTH] = wd[slice_lo(j, WIDTH) +: WIDTH];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .NRD  (NRD),
    .NWR  (NWR)
  ) u_sb (
    .clk     (clk),
    .reset_n (reset_n),
    .iss_v   (iss_v),
    .iss_a   (iss_a),
    .we      (we),
    .wa      (wa),
    .wb_clr  (wb_clr),
    .ra      (ra),
    .rd_busy (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with a per-cycle behavioural model.
// Literal checks pin the model at the key scenarios.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] ra;
  logic [95:0] rd;
  logic [2:0]  rd_busy;
  logic [1:0]  we;
  logic [7:0]  wa;
  logic [63:0] wd;
  logic [31:0] pc_val;
  logic        iss_v;
  logic [3:0]  iss_a;
  logic [1:0]  wb_clr;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_regs [16];
  bit          m_busy [16];

  regfile_mp dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ra      (ra),
    .rd      (rd),
    .rd_busy (rd_busy),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .pc_val  (pc_val),
    .iss_v   (iss_v),
    .iss_a   (iss_a),
    .wb_clr  (wb_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ra_of(input int i);
    return ra[i*4 +: 4];
  endfunction

  function automatic logic [3:0] wa_of(input int j);
    return wa[j*4 +: 4];
  endfunction

  // Expected read value: PC alias, else latest enabled writer, else storage.
  function automatic logic [31:0] exp_rd(input int i);
    logic [3:0] a;
    logic [31:0] v;
    a = ra_of(i);
    if (int'(a) == PC_IDX) return pc_val;
    v = m_regs[a];
    for (int j = 0; j < 2; j++)
      if (we[j] && wa_of(j) == a) v = wd[j*32 +: 32];
    return v;
  endfunction

  function automatic logic exp_busy(input int i);
    logic [3:0] a;
    a = ra_of(i);
    if (int'(a) == PC_IDX) return 1'b0;
    for (int j = 0; j < 2; j++)
      if (we[j] && wb_clr[j] && wa_of(j) == a) return 1'b0;
    return m_busy[a];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 16; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (we[j] && int'(wa_of(j)) != PC_IDX)
          m_regs[wa_of(j)] = wd[j*32 +: 32];
        if (we[j] && wb_clr[j])
          m_busy[wa_of(j)] = 1'b0;
      end
      if (iss_v && int'(iss_a) != PC_IDX)
        m_busy[iss_a] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("model_rd%0d", i), rd[i*32 +: 32], exp_rd(i));
        check($sformatf("model_busy%0d", i), {31'b0, rd_busy[i]},
              {31'b0, exp_busy(i)});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    we = '0;
    wb_clr = '0;
    iss_v = 1'b0;
  endtask

  task automatic wr(input int j, input logic [3:0] a,
                    input logic [31:0] d, input logic c);
    we[j] = 1'b1;
    wa[j*4 +: 4] = a;
    wd[j*32 +: 32] = d;
    wb_clr[j] = c;
  endtask

  task automatic issue(input logic [3:0] a);
    iss_v = 1'b1;
    iss_a = a;
  endtask

  initial begin
    reset_n = 1'b0;
    ra = '0;
    we = '0;
    wa = '0;
    wd = '0;
    wb_clr = '0;
    iss_v = 1'b0;
    iss_a = '0;
    pc_val = 32'h100;
    repeat (2) cyc();
    #1;
    check("reset_rd0", rd[31:0], 32'h0);
    check("reset_busy", {29'b0, rd_busy}, 32'h0);
    cyc();
    reset_n = 1'b1;
    chk_en = 1'b1;

    // Write R3 and put a producer on R2, then reset asynchronously.
    cyc();
    wr(0, 4'd3, 32'hDEADBEEF, 1'b0);
    issue(4'd2);
    cyc();
    ra[3:0] = 4'd3;
    ra[7:4] = 4'd2;
    #1;
    check("pre_reset_r3", rd[31:0], 32'hDEADBEEF);
    check("pre_reset_busy_r2", {31'b0, rd_busy[1]}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("async_reset_r3", rd[31:0], 32'h0);
    check("async_reset_busy", {29'b0, rd_busy}, 32'h0);
    repeat (2) cyc();
    reset_n = 1'b1;

    // Bypass then storage.
    cyc();
    wr(0, 4'd5, 32'h1234, 1'b0);
    ra[7:4] = 4'd5;
    #1;
    check("bypass_r5", rd[63:32], 32'h1234);
    cyc();
    #1;
    check("stored_r5", rd[63:32], 32'h1234);

    // Collision on R7.
    cyc();
    wr(0, 4'd7, 32'hA, 1'b0);
    wr(1, 4'd7, 32'hB, 1'b0);
    ra[11:8] = 4'd7;
    #1;
    check("collide_bypass", rd[95:64], 32'hB);
    cyc();
    #1;
    check("collide_stored", rd[95:64], 32'hB);

    // PC index: writes and issues ignored.
    cyc();
    wr(0, 4'd15, 32'h55, 1'b0);
    issue(4'd15);
    ra[3:0] = 4'd15;
    #1;
    check("pc_read", rd[31:0], 32'h100);
    check("pc_busy", {31'b0, rd_busy[0]}, 32'h0);
    cyc();
    #1;
    check("pc_after", rd[31:0], 32'h100);
    check("pc_busy_after", {31'b0, rd_busy[0]}, 32'h0);

    // Scoreboard on R9.
    cyc();
    issue(4'd9);
    ra[3:0] = 4'd9;
    #1;
    check("r9_not_yet_busy", {31'b0, rd_busy[0]}, 32'h0);
    cyc();
    #1;
    check("r9_busy", {31'b0, rd_busy[0]}, 32'h1);
    cyc();
    wr(1, 4'd9, 32'h77, 1'b1);
    #1;
    check("r9_clr_busy", {31'b0, rd_busy[0]}, 32'h0);
    check("r9_clr_rd", rd[31:0], 32'h77);
    cyc();
    #1;
    check("r9_cleared", {31'b0, rd_busy[0]}, 32'h0);
    check("r9_stored", rd[31:0], 32'h77);

    // Set and clear in the same cycle: set wins.
    cyc();
    issue(4'd9);
    cyc();
    wr(1, 4'd9, 32'h88, 1'b1);
    issue(4'd9);
    #1;
    check("r9_masked", {31'b0, rd_busy[0]}, 32'h0);
    cyc();
    #1;
    check("r9_set_wins", {31'b0, rd_busy[0]}, 32'h1);
    check("r9_new_val", rd[31:0], 32'h88);

    // Long multiply into R4/R5.
    cyc();
    issue(4'd4);
    cyc();
    issue(4'd5);
    cyc();
    ra = {4'd0, 4'd5, 4'd4};
    #1;
    check("mul_busy", {29'b0, rd_busy}, 32'h3);
    wr(0, 4'd4, 32'h11112222, 1'b1);
    wr(1, 4'd5, 32'h33334444, 1'b1);
    #1;
    check("mul_lo", rd[31:0], 32'h11112222);
    check("mul_hi", rd[63:32], 32'h33334444);
    check("mul_r0", rd[95:64], 32'h0);
    check("mul_busy_clr", {29'b0, rd_busy}, 32'h0);
    cyc();
    #1;
    check("mul_lo_st", rd[31:0], 32'h11112222);
    check("mul_hi_st", rd[63:32], 32'h33334444);
    check("mul_busy_st", {29'b0, rd_busy}, 32'h0);

    // Retire on an already-clear bit is a no-op.
    cyc();
    wr(0, 4'd4, 32'h5, 1'b1);
    cyc();
    #1;
    check("noop_clr", {31'b0, rd_busy[0]}, 32'h0);

    repeat (2) cyc();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
